// File: rtl/s2p_a_pkg.sv
// s2p_a_pkg: constants and types shared by the activation serializer (p2s)
// and collector (s2p) blocks.
//   DW       - width of one signed activation word
//   N        - words per frame (neurons per layer slice)
//   CW       - width of the word-index counter
//   SEL_IDLE - layer-select code meaning "block idle"
//   act_t    - signed activation word
package s2p_a_pkg;
   localparam int DW = 16;
   localparam int N  = 5;
   localparam int CW = $clog2(N);

   localparam logic [3:0] SEL_IDLE = 4'b0000;

   typedef logic signed [DW-1:0] act_t;
endpackage

// File: rtl/s2p_a_if.sv
// s2p_a_if: serial word input and parallel frame output of the collector.
//   a_valid / a / a_ready          - serial word handshake (producer -> s2p)
//   out_valid / out_ready / a_par  - parallel frame handshake (s2p -> loader)
//   a_par[k] is word k of the frame, word 0 = first received, k at bits
//   [(k+1)*DW-1 : k*DW]; each element keeps the signed act_t type.
// Modports: master = producer/loader side, slave = collector side.
interface s2p_a_if;
   import s2p_a_pkg::*;

   logic               a_valid;
   act_t               a;
   logic               a_ready;
   logic               out_valid;
   logic               out_ready;
   act_t [N-1:0]       a_par;

   modport master (
      output a_valid, a, out_ready,
      input  a_ready, out_valid, a_par
   );

   modport slave (
      input  a_valid, a, out_ready,
      output a_ready, out_valid, a_par
   );
endinterface

// File: rtl/s2p_a.sv
// s2p_a: serial-to-parallel activation collector.
// Gathers N consecutive signed words into a collect buffer; the last word of
// a frame is written together with the first N-1 into the output buffer,
// which drives the parallel bus under a valid/ready handshake.
// Ports:
//   clk  - clock, rising edge
//   rst  - synchronous reset, active low
//   sel  - layer select; SEL_IDLE stops word acceptance
//   clr  - abort the partial frame (idx back to 0), output side untouched
//   busy - partial frame in progress
//   s    - serial in / parallel out handshakes (s2p_a_if.slave)
module s2p_a
   import s2p_a_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] sel,
   input  logic       clr,
   output logic       busy,
   s2p_a_if.slave     s
);

   localparam logic [CW-1:0] LAST = CW'(N-1);

   logic [CW-1:0]  idx;
   act_t [N-2:0]   cmem;   // last word never lands here; it goes straight to omem
   act_t [N-1:0]   omem;
   logic           ovld;
   logic           acc;
   logic           last;

   assign last = (idx == LAST);

   // The final word needs a free output slot (or one being drained this
   // cycle); earlier words only need the block enabled and not aborting.
   assign s.a_ready = (sel != SEL_IDLE) && !clr &&
                      (!last || !ovld || s.out_ready);
   assign acc       = s.a_valid && s.a_ready;

   assign s.out_valid = ovld;
   assign s.a_par     = omem;
   assign busy        = (idx != '0);

   always_ff @(posedge clk) begin
      if (!rst) begin
         idx  <= '0;
         cmem <= '0;
         omem <= '0;
         ovld <= 1'b0;
      end else begin
         if (clr) begin
            idx <= '0;
         end else if (acc) begin
            if (last) begin
               omem[N-2:0] <= cmem;
               omem[N-1]   <= s.a;
               idx         <= '0;
            end else begin
               for (int k = 0; k < N-1; k++)
                  if (idx == CW'(k)) cmem[k] <= s.a;
               idx <= idx + CW'(1);
            end
         end

         // A completing frame wins over a consume: back-to-back frames
         // keep out_valid high with no bubble.
         if (acc && last)
            ovld <= 1'b1;
         else if (s.out_ready)
            ovld <= 1'b0;
      end
   end

endmodule

// File: tb/tb_s2p_a.sv
// tb_s2p_a: directed self-checking bench for s2p_a.
module tb_s2p_a;
   import s2p_a_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] sel;
   logic       clr;
   logic       busy;

   s2p_a_if ifc ();

   s2p_a dut (
      .clk  (clk),
      .rst  (rst),
      .sel  (sel),
      .clr  (clr),
      .busy (busy),
      .s    (ifc)
   );

   always #5 clk = ~clk;

   int errs  = 0;
   int total = 0;
   int nrdy  = 0;

   task automatic chk(input string tag, input logic [N*DW-1:0] obs,
                      input logic [N*DW-1:0] exp);
      total++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [N*DW-1:0] frm(input int w0, input int w1,
                                           input int w2, input int w3,
                                           input int w4);
      return {DW'(w4), DW'(w3), DW'(w2), DW'(w1), DW'(w0)};
   endfunction

   // advance one edge; inputs are driven and outputs sampled 1 time unit after it
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // present one word for one edge; counts cycles where a_ready was low
   task automatic feed(input int w);
      ifc.a_valid = 1'b1;
      ifc.a       = DW'(w);
      #1;
      if (!ifc.a_ready) nrdy++;
      step();
   endtask

   initial begin
      rst = 1'b0; sel = 4'd0; clr = 1'b0;
      ifc.a_valid = 1'b0; ifc.a = '0; ifc.out_ready = 1'b0;

      // ---------------- reset + basic frame ----------------
      step(); step();
      rst = 1'b1;
      chk("rst_ovld", 80'(ifc.out_valid), 80'(0));
      chk("rst_busy", 80'(busy), 80'(0));
      chk("rst_apar", ifc.a_par, '0);

      sel = 4'd1; ifc.out_ready = 1'b1;
      feed(1); feed(-2); feed(3); feed(-4);
      chk("basic_ovld_pre", 80'(ifc.out_valid), 80'(0));
      chk("basic_busy", 80'(busy), 80'(1));
      feed(5);
      ifc.a_valid = 1'b0;
      chk("basic_ovld", 80'(ifc.out_valid), 80'(1));
      chk("basic_apar", ifc.a_par, frm(1, -2, 3, -4, 5));
      chk("basic_busy0", 80'(busy), 80'(0));
      step();
      chk("basic_ovld_drop", 80'(ifc.out_valid), 80'(0));
      chk("basic_nrdy", 80'(nrdy), 80'(0));

      // ---------------- backpressure ----------------
      ifc.out_ready = 1'b0;
      feed(10); feed(11); feed(12); feed(13); feed(14);
      chk("bp_A_ovld", 80'(ifc.out_valid), 80'(1));
      chk("bp_A_apar", ifc.a_par, frm(10, 11, 12, 13, 14));
      feed(20); feed(21); feed(22); feed(23);
      chk("bp_B_nrdy", 80'(nrdy), 80'(0));
      ifc.a_valid = 1'b1; ifc.a = DW'(24);
      #1;
      chk("bp_stall_rdy", 80'(ifc.a_ready), 80'(0));
      step();
      chk("bp_hold_apar", ifc.a_par, frm(10, 11, 12, 13, 14));
      chk("bp_hold_ovld", 80'(ifc.out_valid), 80'(1));
      chk("bp_hold_busy", 80'(busy), 80'(1));
      ifc.out_ready = 1'b1;
      #1;
      chk("bp_release_rdy", 80'(ifc.a_ready), 80'(1));
      step();
      ifc.a_valid = 1'b0;
      chk("bp_B_ovld", 80'(ifc.out_valid), 80'(1));
      chk("bp_B_apar", ifc.a_par, frm(20, 21, 22, 23, 24));
      step();
      chk("bp_B_drop", 80'(ifc.out_valid), 80'(0));

      // ---------------- back-to-back streaming ----------------
      nrdy = 0;
      for (int i = 0; i < 15; i++) begin
         feed(i);
         chk($sformatf("stream_ovld_%0d", i), 80'(ifc.out_valid),
             80'(i % 5 == 4));
         if (i % 5 == 4)
            chk($sformatf("stream_apar_%0d", i), ifc.a_par,
                frm(i-4, i-3, i-2, i-1, i));
      end
      ifc.a_valid = 1'b0;
      chk("stream_nrdy", 80'(nrdy), 80'(0));
      step();
      chk("stream_drop", 80'(ifc.out_valid), 80'(0));

      // ---------------- abort ----------------
      feed(7); feed(8); feed(9);
      chk("abort_busy_pre", 80'(busy), 80'(1));
      ifc.a_valid = 1'b1; ifc.a = DW'(99); clr = 1'b1;
      #1;
      chk("abort_rdy", 80'(ifc.a_ready), 80'(0));
      step();
      clr = 1'b0;
      chk("abort_busy", 80'(busy), 80'(0));
      feed(1); feed(2); feed(3); feed(4); feed(5);
      ifc.a_valid = 1'b0;
      chk("abort_ovld", 80'(ifc.out_valid), 80'(1));
      chk("abort_apar", ifc.a_par, frm(1, 2, 3, 4, 5));
      step();

      // ---------------- sel idle ----------------
      feed(30); feed(31);
      sel = 4'd0; ifc.a_valid = 1'b1; ifc.a = DW'(32);
      for (int i = 0; i < 4; i++) begin
         #1;
         chk($sformatf("idle_rdy_%0d", i), 80'(ifc.a_ready), 80'(0));
         step();
         chk($sformatf("idle_busy_%0d", i), 80'(busy), 80'(1));
      end
      sel = 4'd2;
      feed(32); feed(33); feed(34);
      ifc.a_valid = 1'b0;
      chk("idle_ovld", 80'(ifc.out_valid), 80'(1));
      chk("idle_apar", ifc.a_par, frm(30, 31, 32, 33, 34));
      step();

      // ---------------- reset mid-operation ----------------
      sel = 4'd1; ifc.out_ready = 1'b0;
      feed(40); feed(41); feed(42); feed(43); feed(44);
      feed(50); feed(51);
      ifc.a_valid = 1'b0;
      chk("mid_ovld_pre", 80'(ifc.out_valid), 80'(1));
      chk("mid_busy_pre", 80'(busy), 80'(1));
      rst = 1'b0;
      step();
      rst = 1'b1;
      chk("mid_rst_ovld", 80'(ifc.out_valid), 80'(0));
      chk("mid_rst_apar", ifc.a_par, '0);
      chk("mid_rst_busy", 80'(busy), 80'(0));
      ifc.out_ready = 1'b1;
      feed(60); feed(-61); feed(62); feed(-63); feed(64);
      ifc.a_valid = 1'b0;
      chk("post_ovld", 80'(ifc.out_valid), 80'(1));
      chk("post_apar", ifc.a_par, frm(60, -61, 62, -63, 64));
      step();
      chk("post_drop", 80'(ifc.out_valid), 80'(0));

      $display("Result: errors=%0d of %0d checks", errs, total);
      $finish;
   end

endmodule
